// File: rtl/fb_pixel_server.sv
// Framebuffer pixel source for the st7735 pixel handshake, with RGB565 palette and write port.
// Optional hardware horizontal scroll is compiled in with `define FB_SCROLL_EN.
module fb_pixel_server #(
    parameter int unsigned X_MAX        = 160,
    parameter int unsigned Y_MAX        = 80,
    parameter int unsigned BPP          = 1,
    parameter logic [15:0] BORDER_COLOR = 16'h0000
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [7:0]     x,
    input  logic [6:0]     y,
    input  logic           next_pixel,
    output logic [15:0]    color,
    output logic           color_done,
    input  logic           wr_valid,
    output logic           wr_ready,
    input  logic [7:0]     wr_x,
    input  logic [6:0]     wr_y,
    input  logic [BPP-1:0] wr_data,
    input  logic           pal_we,
    input  logic [BPP-1:0] pal_idx,
    input  logic [15:0]    pal_data,
    input  logic [7:0]     scroll_x,
    input  logic           scroll_load,
    output logic           frame_start
);

    localparam int unsigned DEPTH = X_MAX * Y_MAX;
    localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned NPAL  = 1 << BPP;
    localparam logic [8:0]  X_LIM = 9'(X_MAX);
    localparam logic [7:0]  Y_LIM = 8'(Y_MAX);

    typedef enum logic [1:0] {IDLE, RD, PAL, DONE} state_t;

    state_t         state_q, state_d;
    logic           next_pixel_q, next_pixel_d;
    logic [BPP-1:0] idx_q, idx_d;
    logic [15:0]    color_q, color_d;
    logic [15:0]    pal_q [NPAL];
    logic [15:0]    pal_d [NPAL];
    logic [BPP-1:0] fb_mem [DEPTH];
    logic [BPP-1:0] rd_data_q;

    logic           pix_edge;
    logic           in_range;
    logic           wr_in_range;
    logic           wr_en;
    logic [8:0]     sx;
    logic [AW-1:0]  rd_addr;
    logic [AW-1:0]  wr_addr;
    logic [AW-1:0]  mem_addr;

    assign pix_edge    = next_pixel && !next_pixel_q;
    assign in_range    = ({1'b0, x} < X_LIM) && ({1'b0, y} < Y_LIM);
    assign wr_in_range = ({1'b0, wr_x} < X_LIM) && ({1'b0, wr_y} < Y_LIM);

`ifdef FB_SCROLL_EN
    logic [7:0] pend_q, pend_d;
    logic [7:0] act_q, act_d;
    logic [7:0] eff_scroll;
    logic [8:0] sx_raw;

    // A (0,0) request promotes pending->active and already uses the promoted value.
    assign eff_scroll = frame_start ? pend_q : act_q;

    always_comb begin
        pend_d = pend_q;
        act_d  = act_q;
        if (frame_start) begin
            act_d = pend_q;
        end
        if (scroll_load && ({1'b0, scroll_x} < X_LIM)) begin
            pend_d = scroll_x;
        end
    end

    always_comb begin
        sx_raw = {1'b0, x} + {1'b0, eff_scroll};
        sx     = (sx_raw >= X_LIM) ? (sx_raw - X_LIM) : sx_raw;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pend_q <= '0;
            act_q  <= '0;
        end else begin
            pend_q <= pend_d;
            act_q  <= act_d;
        end
    end
`else
    logic unused_scroll;

    assign sx            = {1'b0, x};
    assign unused_scroll = ^{scroll_x, scroll_load};
`endif

    assign rd_addr  = AW'(y) * AW'(X_MAX) + AW'(sx);
    assign wr_addr  = AW'(wr_y) * AW'(X_MAX) + AW'(wr_x);
    assign wr_en    = wr_valid && wr_ready && wr_in_range;
    assign mem_addr = wr_en ? wr_addr : rd_addr;

    // Single-port framebuffer, registered read.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            fb_mem[mem_addr] <= wr_data;
        end
        rd_data_q <= fb_mem[mem_addr];
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (pix_edge) state_d = in_range ? RD : DONE;
            RD:   state_d = PAL;
            PAL:  state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        color_done  = 1'b0;
        wr_ready    = 1'b0;
        frame_start = 1'b0;
        if (reset) begin
            case (state_q)
                IDLE: begin
                    wr_ready    = !pix_edge;
                    frame_start = pix_edge && (x == '0) && (y == '0);
                end
                DONE:    color_done = 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        next_pixel_d = next_pixel;
        idx_d        = idx_q;
        color_d      = color_q;
        case (state_q)
            IDLE: if (pix_edge && !in_range) color_d = BORDER_COLOR;
            RD:   idx_d   = rd_data_q;
            PAL:  color_d = pal_q[idx_q];
            default: ;
        endcase
    end

    always_comb begin
        pal_d = pal_q;
        if (pal_we) begin
            pal_d[pal_idx] = pal_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            next_pixel_q <= 1'b0;
            idx_q        <= '0;
            color_q      <= '0;
            for (int unsigned i = 0; i < NPAL; i++) begin
                pal_q[i] <= (i == 0) ? 16'h0000 : 16'hFFFF;
            end
        end else begin
            next_pixel_q <= next_pixel_d;
            idx_q        <= idx_d;
            color_q      <= color_d;
            pal_q        <= pal_d;
        end
    end

    assign color = color_q;

endmodule

// File: tb/tb_fb_pixel_server.sv
// Randomised self-checking bench for fb_pixel_server against a behavioural framebuffer/palette model.
// Scroll expectations follow FB_SCROLL_EN when it is defined for the build.
`timescale 1ns/1ps
module tb_fb_pixel_server;

    localparam int unsigned X_MAX  = 160;
    localparam int unsigned Y_MAX  = 80;
    localparam int unsigned BPP    = 1;
    localparam int unsigned NPAL   = 1 << BPP;
    localparam logic [15:0] BORDER = 16'h0000;

    logic           clk = 1'b0;
    logic           reset;
    logic [7:0]     x;
    logic [6:0]     y;
    logic           next_pixel;
    logic [15:0]    color;
    logic           color_done;
    logic           wr_valid;
    logic           wr_ready;
    logic [7:0]     wr_x;
    logic [6:0]     wr_y;
    logic [BPP-1:0] wr_data;
    logic           pal_we;
    logic [BPP-1:0] pal_idx;
    logic [15:0]    pal_data;
    logic [7:0]     scroll_x;
    logic           scroll_load;
    logic           frame_start;

    always #5 clk = ~clk;

    fb_pixel_server #(
        .X_MAX(X_MAX),
        .Y_MAX(Y_MAX),
        .BPP(BPP),
        .BORDER_COLOR(BORDER)
    ) dut (
        .clk(clk),
        .reset(reset),
        .x(x),
        .y(y),
        .next_pixel(next_pixel),
        .color(color),
        .color_done(color_done),
        .wr_valid(wr_valid),
        .wr_ready(wr_ready),
        .wr_x(wr_x),
        .wr_y(wr_y),
        .wr_data(wr_data),
        .pal_we(pal_we),
        .pal_idx(pal_idx),
        .pal_data(pal_data),
        .scroll_x(scroll_x),
        .scroll_load(scroll_load),
        .frame_start(frame_start)
    );

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    logic [BPP-1:0] fb_m [Y_MAX][X_MAX];
    logic [15:0]    pal_m [NPAL];
`ifdef FB_SCROLL_EN
    int unsigned pend_m, act_m;
`endif

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < int'(NPAL); i++) pal_m[i] = (i == 0) ? 16'h0000 : 16'hFFFF;
`ifdef FB_SCROLL_EN
        pend_m = 0;
        act_m  = 0;
`endif
    endfunction

    function automatic int unsigned model_col(input int unsigned cx);
`ifdef FB_SCROLL_EN
        return (cx + act_m) % X_MAX;
`else
        return cx;
`endif
    endfunction

    // All tasks start and end just after a falling clock edge.
    task automatic fb_write(input int unsigned wx, input int unsigned wy, input logic [BPP-1:0] d, input bit chk);
        int unsigned k = 0;
        wr_x = 8'(wx); wr_y = 7'(wy); wr_data = d; wr_valid = 1'b1;
        #1;
        while (!wr_ready && k < 10) begin
            @(negedge clk); #1; k++;
        end
        if (chk || !wr_ready) check_eq("wr_ready", {31'b0, wr_ready}, 1);
        @(negedge clk);
        wr_valid = 1'b0;
        if (wx < X_MAX && wy < Y_MAX) fb_m[wy][wx] = d;
    endtask

    task automatic pal_write(input int unsigned idx, input logic [15:0] val);
        pal_we = 1'b1; pal_idx = BPP'(idx); pal_data = val;
        @(negedge clk);
        pal_we = 1'b0;
        pal_m[idx] = val;
    endtask

    task automatic load_scroll(input int unsigned v);
        scroll_x = 8'(v); scroll_load = 1'b1;
        @(negedge clk);
        scroll_load = 1'b0;
`ifdef FB_SCROLL_EN
        if (v < X_MAX) pend_m = v;
`endif
    endtask

    task automatic request(input int unsigned rx, input int unsigned ry);
        bit          in_r, fs;
        int unsigned exp_lat, k;
        logic [15:0] exp_c;
        in_r = (rx < X_MAX) && (ry < Y_MAX);
        fs   = in_r && rx == 0 && ry == 0;
`ifdef FB_SCROLL_EN
        if (fs) act_m = pend_m;
`endif
        if (in_r) begin
            exp_c   = pal_m[fb_m[ry][model_col(rx)]];
            exp_lat = 3;
        end else begin
            exp_c   = BORDER;
            exp_lat = 1;
        end
        x = 8'(rx); y = 7'(ry); next_pixel = 1'b1;
        #1;
        check_eq("frame_start", {31'b0, frame_start}, {31'b0, fs});
        check_eq("wr_ready_edge", {31'b0, wr_ready}, 0);
        @(negedge clk);
        next_pixel = 1'b0;
        k = 1;
        while (!color_done && k < 8) begin
            @(negedge clk); k++;
        end
        if (!color_done) k = 99;
        check_eq("latency", k, exp_lat);
        check_eq("color", {16'b0, color}, {16'b0, exp_c});
        @(negedge clk);
        check_eq("done_pulse", {31'b0, color_done}, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int unsigned    col, pi, op;
        logic [BPP-1:0] oldv;
        logic [15:0]    oldc, newc;

        reset = 1'b0; next_pixel = 1'b1; x = '0; y = '0;
        wr_valid = 1'b0; wr_x = '0; wr_y = '0; wr_data = '0;
        pal_we = 1'b0; pal_idx = '0; pal_data = '0;
        scroll_x = '0; scroll_load = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_color", {16'b0, color}, 0);
        check_eq("rst_done", {31'b0, color_done}, 0);
        check_eq("rst_wr_ready", {31'b0, wr_ready}, 0);
        check_eq("rst_frame_start", {31'b0, frame_start}, 0);
        next_pixel = 1'b0;
        @(negedge clk);
        model_reset();
        reset = 1'b1;
        @(negedge clk);
        check_eq("idle_wr_ready", {31'b0, wr_ready}, 1);

        for (int unsigned fy = 0; fy < Y_MAX; fy++)
            for (int unsigned fx = 0; fx < X_MAX; fx++)
                fb_write(fx, fy, '0, 1'b0);

        request(5, 3);
        fb_write(10, 2, 1, 1'b1);
        request(10, 2);
        pal_write(1, 16'hF800);
        request(10, 2);
        request(160, 0);
        request(0, 80);

        fb_write(7, 2, 0, 1'b1);
        fb_write(2, 2, 1, 1'b1);
        load_scroll(155);
        request(10, 2);
        request(0, 0);
        request(7, 2);
        load_scroll(200);
        request(0, 0);
        request(7, 2);

        // Write held across a display read of the same location.
        col  = model_col(20);
        oldv = fb_m[5][col];
        x = 8'd20; y = 7'd5; next_pixel = 1'b1;
        wr_x = 8'(col); wr_y = 7'd5; wr_data = ~oldv; wr_valid = 1'b1;
        #1;
        check_eq("stall_edge", {31'b0, wr_ready}, 0);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            if (k == 1) next_pixel = 1'b0;
            check_eq("stall_busy", {31'b0, wr_ready}, 0);
        end
        check_eq("stall_done", {31'b0, color_done}, 1);
        check_eq("stall_color", {16'b0, color}, {16'b0, pal_m[oldv]});
        @(negedge clk);
        check_eq("stall_release", {31'b0, wr_ready}, 1);
        @(negedge clk);
        wr_valid = 1'b0;
        fb_m[5][col] = ~oldv;
        request(20, 5);

        // Palette write to the index being looked up in PAL.
        col  = model_col(10);
        pi   = int'(fb_m[2][col]);
        oldc = pal_m[pi];
        newc = ~oldc;
        x = 8'd10; y = 7'd2; next_pixel = 1'b1;
        @(negedge clk);
        next_pixel = 1'b0;
        @(negedge clk);
        pal_we = 1'b1; pal_idx = BPP'(pi); pal_data = newc;
        @(negedge clk);
        pal_we = 1'b0;
        check_eq("palrace_done", {31'b0, color_done}, 1);
        check_eq("palrace_color", {16'b0, color}, {16'b0, oldc});
        pal_m[pi] = newc;
        @(negedge clk);
        request(10, 2);

        // Reset landing on the PAL state.
        x = 8'd30; y = 7'd7; next_pixel = 1'b1;
        @(negedge clk);
        next_pixel = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_eq("rstpal_done", {31'b0, color_done}, 0);
        check_eq("rstpal_color", {16'b0, color}, 0);
        model_reset();
        reset = 1'b1;
        @(negedge clk);
        check_eq("rstpal_after", {31'b0, color_done}, 0);
        request(30, 7);

        for (int it = 0; it < 400; it++) begin
            op = $urandom_range(0, 9);
            case (op)
                0, 1, 2: fb_write($urandom_range(0, 169), $urandom_range(0, 89), BPP'($urandom), 1'b1);
                3:       pal_write($urandom_range(0, NPAL - 1), 16'($urandom));
                4:       load_scroll($urandom_range(0, 255));
                5:       request(0, 0);
                default: request($urandom_range(0, 175), $urandom_range(0, 95));
            endcase
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
